// File: rtl/axi_read_responder.sv
// rtl/axi_read_responder.sv - in-order AXI-style read responder with programmable latency and address-derived beat data.
// Optional RD_RESP_RANDOM_STALL_EN inserts LFSR-driven bubbles between beats.
module axi_read_responder #(
  parameter int ADDR_BITS            = 64,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 0,
  parameter int LOG_QUEUE_SIZE       = 2,
  parameter int LAT_WIDTH            = 8,
  localparam int BLOCK_DATA_SIZE_BITS = 8 << LOG_BLOCK_DATA_BYTES
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ar_valid,
  output logic                            ar_ready,
  input  logic [ADDR_BITS-1:0]            ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]      ar_len,
  input  logic [TID_WIDTH-1:0]            ar_id,
  output logic                            r_valid,
  input  logic                            r_ready,
  output logic [BLOCK_DATA_SIZE_BITS-1:0] r_data,
  output logic [TID_WIDTH-1:0]            r_id,
  output logic                            r_last,
  input  logic [LAT_WIDTH-1:0]            lat,
  output logic [LOG_QUEUE_SIZE+1:0]       outstanding
);

  localparam int DEPTH = 1 << LOG_QUEUE_SIZE;
  localparam int CW    = LOG_QUEUE_SIZE + 1;
  localparam int OW    = LOG_QUEUE_SIZE + 2;
  localparam logic [ADDR_BITS-1:0] STEP = ADDR_BITS'(1 << LOG_BLOCK_DATA_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  logic [ADDR_BITS-1:0]       addr_mem_q [DEPTH];
  logic [BURST_LEN_WIDTH-1:0] len_mem_q  [DEPTH];
  logic [TID_WIDTH-1:0]       id_mem_q   [DEPTH];
  logic [LOG_QUEUE_SIZE-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              count_q, count_d;
  logic [OW-1:0]              outstanding_q, outstanding_d;
  logic                       ar_ready_q;

  state_t                     state_q;
  logic [ADDR_BITS-1:0]       addr_q;
  logic [BURST_LEN_WIDTH-1:0] beats_left_q;
  logic [TID_WIDTH-1:0]       id_q;
  logic [LAT_WIDTH-1:0]       lat_cnt_q;
  logic                       r_valid_q, r_last_q;

  logic push, pop, beat_hs, last_hs, empty, beat_ok;

`ifdef RD_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign beat_ok = ~lfsr_q[0];
`else
  assign beat_ok = 1'b1;
`endif

  always_comb begin
    empty         = (count_q == '0);
    push          = ar_valid && ar_ready_q;
    beat_hs       = (state_q == BURST) && r_valid_q && r_ready;
    last_hs       = beat_hs && (beats_left_q == '0);
    pop           = !empty && ((state_q == IDLE) || last_hs);
    count_d       = count_q + CW'(push) - CW'(pop);
    outstanding_d = outstanding_q + OW'(push) - OW'(last_hs);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= ar_addr;
      len_mem_q[wr_ptr_q]  <= ar_len;
      id_mem_q[wr_ptr_q]   <= ar_id;
    end
  end

  // ar_ready is registered from next-state occupancy, so a pop never frees a slot in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      ar_ready_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      ar_ready_q    <= (count_d != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      id_q         <= '0;
      lat_cnt_q    <= '0;
      r_valid_q    <= 1'b0;
      r_last_q     <= 1'b0;
    end else if (pop) begin
      addr_q       <= addr_mem_q[rd_ptr_q];
      beats_left_q <= len_mem_q[rd_ptr_q];
      id_q         <= id_mem_q[rd_ptr_q];
      lat_cnt_q    <= lat;
      if (lat == '0) begin
        state_q   <= BURST;
        r_valid_q <= beat_ok;
        r_last_q  <= (len_mem_q[rd_ptr_q] == '0);
      end else begin
        state_q   <= WAIT;
        r_valid_q <= 1'b0;
        r_last_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        WAIT: begin
          if (lat_cnt_q == LAT_WIDTH'(1)) begin
            state_q   <= BURST;
            r_valid_q <= beat_ok;
            r_last_q  <= (beats_left_q == '0);
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        BURST: begin
          if (beat_hs) begin
            if (beats_left_q == '0) begin
              state_q   <= IDLE;
              r_valid_q <= 1'b0;
              r_last_q  <= 1'b0;
            end else begin
              addr_q       <= addr_q + STEP;
              beats_left_q <= beats_left_q - 1'b1;
              r_last_q     <= (beats_left_q == BURST_LEN_WIDTH'(1));
              r_valid_q    <= beat_ok;
            end
          end else if (!r_valid_q) begin
            r_valid_q <= beat_ok;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ar_ready    = ar_ready_q;
  assign r_valid     = r_valid_q;
  assign r_last      = r_last_q;
  assign r_id        = id_q;
  assign r_data      = addr_q[BLOCK_DATA_SIZE_BITS-1:0];
  assign outstanding = outstanding_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// tb/tb_axi_read_responder.sv - directed self-checking bench for axi_read_responder.
module tb_axi_read_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [7:0]  ar_id;
  logic        r_valid;
  logic        r_ready;
  logic [7:0]  r_data;
  logic [7:0]  r_id;
  logic        r_last;
  logic [7:0]  lat;
  logic [3:0]  outstanding;

  int total = 0;
  int bad   = 0;

  axi_read_responder dut (
    .clk         (clk),
    .reset       (reset),
    .ar_valid    (ar_valid),
    .ar_ready    (ar_ready),
    .ar_addr     (ar_addr),
    .ar_len      (ar_len),
    .ar_id       (ar_id),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .r_data      (r_data),
    .r_id        (r_id),
    .r_last      (r_last),
    .lat         (lat),
    .outstanding (outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with ar_ready high; returns at cycle t+1 after the handshake edge t.
  task automatic issue(input logic [63:0] a, input logic [7:0] l, input logic [7:0] id);
    chk("ar_ready_before_issue", ar_ready, 1);
    ar_valid = 1'b1;
    ar_addr  = a;
    ar_len   = l;
    ar_id    = id;
    @(negedge clk);
    ar_valid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] id, input logic [7:0] data, input logic last);
    chk({tag, "_valid"}, r_valid, 1);
    chk({tag, "_data"}, r_data, data);
    chk({tag, "_id"}, r_id, id);
    chk({tag, "_last"}, r_last, last);
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    ar_valid = 1'b0;
    ar_addr  = '0;
    ar_len   = '0;
    ar_id    = '0;
    r_ready  = 1'b1;
    lat      = '0;
    repeat (3) @(negedge clk);
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_last", r_last, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_r_id", r_id, 0);
    chk("rst_outstanding", outstanding, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ar_ready", ar_ready, 1);

    // single burst, zero latency
    issue(64'hdeadbeef, 8'd3, 8'd5);
    chk("t1_outstanding_t1", outstanding, 1);
    chk("t1_valid_t1", r_valid, 0);
    @(negedge clk);
    expect_beat("t1_b0", 8'd5, 8'hef, 1'b0);
    expect_beat("t1_b1", 8'd5, 8'hf0, 1'b0);
    chk("t1_outstanding_mid", outstanding, 1);
    expect_beat("t1_b2", 8'd5, 8'hf1, 1'b0);
    expect_beat("t1_b3", 8'd5, 8'hf2, 1'b1);
    chk("t1_valid_after", r_valid, 0);
    chk("t1_outstanding_after", outstanding, 0);

    // latency 5: first beat at t+7
    lat = 8'd5;
    issue(64'hdeadbeef, 8'd3, 8'd5);
    for (int i = 1; i <= 6; i++) begin
      chk($sformatf("t2_wait_valid_%0d", i), r_valid, 0);
      chk($sformatf("t2_wait_outst_%0d", i), outstanding, 1);
      @(negedge clk);
    end
    lat = 8'd0;
    expect_beat("t2_b0", 8'd5, 8'hef, 1'b0);
    expect_beat("t2_b1", 8'd5, 8'hf0, 1'b0);
    expect_beat("t2_b2", 8'd5, 8'hf1, 1'b0);
    expect_beat("t2_b3", 8'd5, 8'hf2, 1'b1);
    chk("t2_outstanding_after", outstanding, 0);

    // backpressure fills the FIFO; 5 requests outstanding
    r_ready  = 1'b0;
    ar_valid = 1'b1;
    ar_addr  = 64'h100;
    ar_len   = 8'd1;
    ar_id    = 8'd10;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        chk($sformatf("t3_ar_ready_%0d", k), ar_ready, 1);
        ar_addr = 64'h100 + 64'(16 * k);
        ar_id   = 8'(10 + k);
      end else begin
        chk($sformatf("t3_ar_ready_%0d", k), ar_ready, 0);
      end
      if (k >= 2) begin
        chk($sformatf("t3_hold_valid_%0d", k), r_valid, 1);
        chk($sformatf("t3_hold_data_%0d", k), r_data, 8'h00);
        chk($sformatf("t3_hold_id_%0d", k), r_id, 10);
        chk($sformatf("t3_hold_last_%0d", k), r_last, 0);
      end
    end
    chk("t3_outstanding_full", outstanding, 5);
    ar_valid = 1'b0;
    r_ready  = 1'b1;
    @(negedge clk);
    expect_beat("t3_a1", 8'd10, 8'h01, 1'b1);
    for (int b = 1; b <= 4; b++) begin
      expect_beat($sformatf("t3_r%0d_b0", b), 8'(10 + b), 8'(16 * b), 1'b0);
      expect_beat($sformatf("t3_r%0d_b1", b), 8'(10 + b), 8'(16 * b + 1), 1'b1);
    end
    chk("t3_drained_valid", r_valid, 0);
    chk("t3_drained_outst", outstanding, 0);
    chk("t3_drained_ready", ar_ready, 1);

    // back-to-back bursts without an idle cycle
    issue(64'h20, 8'd0, 8'd1);
    ar_valid = 1'b1;
    ar_addr  = 64'h40;
    ar_len   = 8'd1;
    ar_id    = 8'd2;
    @(negedge clk);
    ar_valid = 1'b0;
    expect_beat("t4_id1", 8'd1, 8'h20, 1'b1);
    expect_beat("t4_id2_b0", 8'd2, 8'h40, 1'b0);
    expect_beat("t4_id2_b1", 8'd2, 8'h41, 1'b1);
    chk("t4_valid_after", r_valid, 0);
    chk("t4_outst_after", outstanding, 0);

    // address wrap
    issue(64'hffffffffffffffff, 8'd1, 8'd3);
    @(negedge clk);
    expect_beat("t5_b0", 8'd3, 8'hff, 1'b0);
    expect_beat("t5_b1", 8'd3, 8'h00, 1'b1);
    chk("t5_valid_after", r_valid, 0);

    // reset during the 2nd beat
    issue(64'hdeadbeef, 8'd3, 8'd6);
    @(negedge clk);
    expect_beat("t6_b0", 8'd6, 8'hef, 1'b0);
    chk("t6_b1_data", r_data, 8'hf0);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", r_valid, 0);
    chk("t6_rst_outst", outstanding, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_quiet_valid", r_valid, 0);
    issue(64'h80, 8'd0, 8'd7);
    @(negedge clk);
    expect_beat("t6_new", 8'd7, 8'h80, 1'b1);
    chk("t6_new_valid_after", r_valid, 0);
    chk("t6_new_outst_after", outstanding, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_responder.md
# axi_read_responder

Synthesizable AXI-style read responder: the memory side of the prefetcher's master read port. It accepts read-address requests on the AR channel, queues them in order, and returns each burst on the R channel. Each burst waits a programmable latency and carries address-derived data, so benches can check every beat. It stands in for DDR in prefetcher top-level simulation and FPGA bring-up.

## Interface
Parameters:
- ADDR_BITS, 64, address width
- BURST_LEN_WIDTH, 8, AR length field width; beats = ar_len + 1
- TID_WIDTH, 8, transaction ID width
- LOG_BLOCK_DATA_BYTES, 0, log2 of bytes per beat; BLOCK_DATA_SIZE_BITS = 8 << LOG_BLOCK_DATA_BYTES
- LOG_QUEUE_SIZE, 2, log2 of request FIFO depth
- LAT_WIDTH, 8, latency config width

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- ar_valid  in  1  request valid
- ar_ready  out  1  request accepted when ar_valid & ar_ready
- ar_addr  in  ADDR_BITS  burst start address
- ar_len  in  BURST_LEN_WIDTH  beats minus one
- ar_id  in  TID_WIDTH  request ID
- r_valid  out  1  beat valid
- r_ready  in  1  beat consumed when r_valid & r_ready
- r_data  out  BLOCK_DATA_SIZE_BITS  beat data
- r_id  out  TID_WIDTH  ID of current burst
- r_last  out  1  final beat of burst
- lat  in  LAT_WIDTH  idle cycles between request pop and first beat
- outstanding  out  LOG_QUEUE_SIZE+2  queued requests plus the active burst

## Operation
- FIFO of depth 2^LOG_QUEUE_SIZE holds {addr, len, id}. ar_ready = !full. There is no bypass: a pop in the same cycle does not raise ar_ready when the FIFO is full.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop it and load the burst registers (addr, beats left = len, id, lat sample). Go to BURST if lat==0, else go to WAIT.
  - WAIT: decrement the latency counter. On the cycle it reads 1, go to BURST.
  - BURST: r_valid high. On a beat handshake, advance the beat address by 2^LOG_BLOCK_DATA_BYTES. When the last beat handshakes, pop the next request if the FIFO is non-empty (same rules as IDLE), otherwise go to IDLE.
- r_data = beat address[BLOCK_DATA_SIZE_BITS-1:0]. Beat address = start addr + beat_index << LOG_BLOCK_DATA_BYTES, modulo 2^ADDR_BITS (wraps silently).
- r_last is high while beats left == 0 in BURST.
- r_valid, r_data, r_id and r_last hold stable while r_valid & !r_ready.
- Bursts are returned strictly in acceptance order, and beats from different bursts are never interleaved.
- outstanding:
  - +1 on AR handshake.
  - −1 on a last-beat handshake.
  - Both in the same cycle: no change.
- lat is sampled only at pop. Changing it affects later bursts only.

## Timing
- Reset values: ar_ready=0 during reset and 1 from the first cycle after; r_valid=0, r_last=0, r_data=0, r_id=0, outstanding=0; FIFO empty; FSM in IDLE.
- AR handshake at edge t → FIFO entry visible in cycle t+1.
  - Popped from IDLE at end of t+1.
  - First r_valid in cycle t+2+lat.
- Burst of N beats with r_ready held high: N consecutive r_valid cycles.
- Back-to-back bursts: the next burst's WAIT/BURST begins in the cycle after the previous last-beat handshake, with no IDLE cycle.
- Reset asserted mid-burst: all state cleared at that edge. The active and queued requests are dropped and no further beats are sent.

## Configuration
- RD_RESP_RANDOM_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle.
  - In BURST, when r_valid is low, a beat is presented only if lfsr[0]==0. This inserts pseudo-random bubbles between beats.
  - Once r_valid is high it stays high until the beat handshakes.
  - The first beat after WAIT is also subject to stalls.
- Undefined: no LFSR is instantiated, and r_valid is continuous throughout BURST.

## Test plan
- Reset, then lat=0, one request addr=64'hdeadbeef, len=3, id=5, r_ready=1 → r_valid in 4 consecutive cycles starting t+2; r_data = ef, f0, f1, f2; r_id=5; r_last on the 4th beat only; outstanding goes 1→0 after the 4th beat.
- lat=5, same request → first beat exactly at t+7; outstanding=1 throughout WAIT.
- Keep ar_valid high with r_ready=0 and LOG_QUEUE_SIZE=2 → 4 accepts into the FIFO, the 5th is popped into the active burst, 6th-cycle ar_ready=0 and stays low; outstanding=5; r_valid and r_data held stable.
- Two requests (id=1 len=0, id=2 len=1) with lat=0 and r_ready=1 → beats id1(last), id2, id2(last) on three consecutive cycles.
- Address 64'hffffffffffffffff, len=1 → r_data ff then 00; no error.
- Assert reset during the 2nd beat of a len=3 burst → next cycle r_valid=0 and outstanding=0; a new request afterwards is served normally.
